// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grant with bus parking, hidden arbitration
// during busy cycles and a grant-acquisition timeout.
module pci_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned IW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            PCI_CLK,
    input  logic            RESET,
    input  logic [NREQ-1:0] REQ_n,
    input  logic            FRAME_n,
    input  logic            IRDY_n,
    output logic [NREQ-1:0] GNT_n,
    output logic [IW-1:0]   GNT_IDX,
    output logic            BUS_IDLE,
    output logic            TIMEOUT_EV
);

    typedef enum logic [1:0] {StTurn, StGrant, StBusy} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] gnt_n_q, gnt_n_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            excl_q, excl_d;
    logic            tev_q, tev_d;
    logic            idle_q;

    logic            idle;
    logic [NREQ-1:0] req;
    logic [IW-1:0]   winner;
    logic            found;
    int unsigned     idx;

    assign idle = FRAME_n & IRDY_n;

    // Round-robin search starting after the owner; the owner itself is visited last.
    always_comb begin
        req = ~REQ_n;
        if (state_q == StTurn && excl_q) begin
            req[owner_q] = 1'b0;
        end
        winner = owner_q;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 32'(owner_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx[IW-1:0]]) begin
                winner = idx[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_n_d = gnt_n_q;
        cnt_d   = '0;
        excl_d  = 1'b0;
        tev_d   = 1'b0;
        unique case (state_q)
            StTurn: begin
                owner_d         = winner;
                gnt_n_d         = '1;
                gnt_n_d[winner] = 1'b0;
                state_d         = StGrant;
            end
            StGrant: begin
                if (!FRAME_n) begin
                    state_d = StBusy;
                end else if (!REQ_n[owner_q] && idle && cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    // Timeout wins over a coincident preemption so the event is reported.
                    gnt_n_d = '1;
                    tev_d   = 1'b1;
                    excl_d  = 1'b1;
                    state_d = StTurn;
                end else if (winner != owner_q) begin
                    gnt_n_d = '1;
                    state_d = StTurn;
                end else if (!REQ_n[owner_q] && idle) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StBusy: begin
                if (idle) begin
                    state_d = StGrant;
                    // Grant already removed during the transaction: the idle gap is the turnaround.
                    if (gnt_n_q[owner_q]) begin
                        owner_d         = winner;
                        gnt_n_d         = '1;
                        gnt_n_d[winner] = 1'b0;
                    end
                end else if (winner != owner_q) begin
                    gnt_n_d = '1;
                end
            end
            default: state_d = StTurn;
        endcase
    end

    always_ff @(posedge PCI_CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StTurn;
            owner_q <= IW'(NREQ - 1);
            gnt_n_q <= '1;
            cnt_q   <= '0;
            excl_q  <= 1'b0;
            tev_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_n_q <= gnt_n_d;
            cnt_q   <= cnt_d;
            excl_q  <= excl_d;
            tev_q   <= tev_d;
            idle_q  <= idle;
        end
    end

    assign GNT_n      = gnt_n_q;
    assign GNT_IDX    = owner_q;
    assign BUS_IDLE   = idle_q;
    assign TIMEOUT_EV = tev_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed self-checking bench for pci_arbiter with NREQ=4, TIMEOUT_CYCLES=16.
module tb_pci_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_n;
    logic       frame_n;
    logic       irdy_n;
    logic [3:0] gnt_n;
    logic [1:0] gnt_idx;
    logic       bus_idle;
    logic       tev;

    int n_run  = 0;
    int n_fail = 0;

    pci_arbiter #(
        .NREQ           (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCI_CLK    (clk),
        .RESET      (rst),
        .REQ_n      (req_n),
        .FRAME_n    (frame_n),
        .IRDY_n     (irdy_n),
        .GNT_n      (gnt_n),
        .GNT_IDX    (gnt_idx),
        .BUS_IDLE   (bus_idle),
        .TIMEOUT_EV (tev)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bring the arbiter to GRANT parked on master 3 with no requests.
    task automatic do_reset();
        rst = 1'b1; req_n = 4'b1111; frame_n = 1'b1; irdy_n = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_n = 4'b1111; frame_n = 1'b1; irdy_n = 1'b1;
        tick(); tick();
        n_run++; if (gnt_n !== 4'b1111) begin n_fail++; $display("FAIL reset_gnt got %b want 1111", gnt_n); end
        n_run++; if (gnt_idx !== 2'd3) begin n_fail++; $display("FAIL reset_idx got %0d want 3", gnt_idx); end
        n_run++; if (bus_idle !== 1'b1 || tev !== 1'b0) begin n_fail++; $display("FAIL reset_flags got idle=%b ev=%b want 1 0", bus_idle, tev); end
        rst = 1'b0;
        #1;
        n_run++; if (gnt_n !== 4'b1111) begin n_fail++; $display("FAIL turn_gnt got %b want 1111", gnt_n); end
        tick();
        n_run++; if (gnt_n !== 4'b0111) begin n_fail++; $display("FAIL park_gnt got %b want 0111", gnt_n); end
        n_run++; if (gnt_idx !== 2'd3) begin n_fail++; $display("FAIL park_idx got %0d want 3", gnt_idx); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        do_reset();
        req_n = 4'b0000;
        tick();
        n_run++; if (gnt_n !== 4'b1111) begin n_fail++; $display("FAIL rot_turn got %b want 1111", gnt_n); end
        tick();
        for (int o = 0; o < 4; o++) begin
            exp_g = ~(4'b0001 << o);
            n_run++; if (gnt_n !== exp_g || gnt_idx !== 2'(o)) begin n_fail++; $display("FAIL rot_grant%0d got %b/%0d want %b/%0d", o, gnt_n, gnt_idx, exp_g, o); end
            frame_n = 1'b0;
            tick();
            n_run++; if (gnt_n !== exp_g) begin n_fail++; $display("FAIL rot_busy%0d got %b want %b", o, gnt_n, exp_g); end
            tick();
            n_run++; if (gnt_n !== 4'b1111) begin n_fail++; $display("FAIL rot_gap%0d got %b want 1111", o, gnt_n); end
            frame_n = 1'b1;
            tick();
        end
        n_run++; if (gnt_n !== 4'b1110 || gnt_idx !== 2'd0) begin n_fail++; $display("FAIL rot_wrap got %b/%0d want 1110/0", gnt_n, gnt_idx); end
    endtask

    task automatic test_latency();
        do_reset();
        req_n = 4'b1011;
        tick();
        n_run++; if (gnt_n !== 4'b1111) begin n_fail++; $display("FAIL lat_turn got %b want 1111", gnt_n); end
        tick();
        n_run++; if (gnt_n !== 4'b1011 || gnt_idx !== 2'd2) begin n_fail++; $display("FAIL lat_grant got %b/%0d want 1011/2", gnt_n, gnt_idx); end
    endtask

    task automatic test_timeout();
        do_reset();
        req_n = 4'b1101;
        tick(); tick();
        n_run++; if (gnt_n !== 4'b1101 || gnt_idx !== 2'd1) begin n_fail++; $display("FAIL to_grant1 got %b/%0d want 1101/1", gnt_n, gnt_idx); end
        for (int i = 0; i < 15; i++) tick();
        n_run++; if (gnt_n !== 4'b1101 || tev !== 1'b0) begin n_fail++; $display("FAIL to_hold15 got %b ev=%b want 1101 ev=0", gnt_n, tev); end
        req_n = 4'b1001;
        tick();
        n_run++; if (gnt_n !== 4'b1111 || tev !== 1'b1) begin n_fail++; $display("FAIL to_fire got %b ev=%b want 1111 ev=1", gnt_n, tev); end
        tick();
        n_run++; if (gnt_n !== 4'b1011 || gnt_idx !== 2'd2 || tev !== 1'b0) begin n_fail++; $display("FAIL to_next got %b/%0d ev=%b want 1011/2 ev=0", gnt_n, gnt_idx, tev); end
        req_n = 4'b1011;
        for (int i = 0; i < 15; i++) tick();
        n_run++; if (gnt_n !== 4'b1011 || tev !== 1'b0) begin n_fail++; $display("FAIL to2_hold got %b ev=%b want 1011 ev=0", gnt_n, tev); end
        tick();
        n_run++; if (gnt_n !== 4'b1111 || tev !== 1'b1) begin n_fail++; $display("FAIL to2_fire got %b ev=%b want 1111 ev=1", gnt_n, tev); end
        tick();
        n_run++; if (gnt_n !== 4'b1011 || gnt_idx !== 2'd2) begin n_fail++; $display("FAIL to2_repark got %b/%0d want 1011/2", gnt_n, gnt_idx); end
    endtask

    task automatic test_hidden_arb();
        do_reset();
        req_n = 4'b1110;
        tick(); tick();
        n_run++; if (gnt_n !== 4'b1110) begin n_fail++; $display("FAIL hid_grant0 got %b want 1110", gnt_n); end
        frame_n = 1'b0;
        tick();
        n_run++; if (gnt_n !== 4'b1110 || bus_idle !== 1'b0) begin n_fail++; $display("FAIL hid_busy got %b idle=%b want 1110 idle=0", gnt_n, bus_idle); end
        tick();
        n_run++; if (gnt_n !== 4'b1110) begin n_fail++; $display("FAIL hid_hold got %b want 1110", gnt_n); end
        req_n = 4'b1010;
        tick();
        n_run++; if (gnt_n !== 4'b1111) begin n_fail++; $display("FAIL hid_remove got %b want 1111", gnt_n); end
        tick();
        n_run++; if (gnt_n !== 4'b1111 || gnt_idx !== 2'd0) begin n_fail++; $display("FAIL hid_stay got %b/%0d want 1111/0", gnt_n, gnt_idx); end
        frame_n = 1'b1;
        tick();
        n_run++; if (gnt_n !== 4'b1011 || gnt_idx !== 2'd2 || bus_idle !== 1'b1) begin n_fail++; $display("FAIL hid_direct got %b/%0d idle=%b want 1011/2 idle=1", gnt_n, gnt_idx, bus_idle); end
    endtask

    task automatic test_park_start_and_reset();
        do_reset();
        frame_n = 1'b0;
        tick();
        n_run++; if (gnt_n !== 4'b0111 || bus_idle !== 1'b0) begin n_fail++; $display("FAIL pk_busy got %b idle=%b want 0111 idle=0", gnt_n, bus_idle); end
        tick();
        n_run++; if (gnt_n !== 4'b0111 || gnt_idx !== 2'd3) begin n_fail++; $display("FAIL pk_hold got %b/%0d want 0111/3", gnt_n, gnt_idx); end
        #3;
        rst = 1'b1;
        #1;
        n_run++; if (gnt_n !== 4'b1111 || bus_idle !== 1'b1 || tev !== 1'b0) begin n_fail++; $display("FAIL mid_rst got %b idle=%b ev=%b want 1111 1 0", gnt_n, bus_idle, tev); end
        frame_n = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_run++; if (gnt_n !== 4'b1111) begin n_fail++; $display("FAIL mid_turn got %b want 1111", gnt_n); end
        tick();
        n_run++; if (gnt_n !== 4'b0111 || gnt_idx !== 2'd3) begin n_fail++; $display("FAIL mid_repark got %b/%0d want 0111/3", gnt_n, gnt_idx); end
    endtask

    initial begin
        rst = 1'b1; req_n = 4'b1111; frame_n = 1'b1; irdy_n = 1'b1;
        test_reset();
        test_rotation();
        test_latency();
        test_timeout();
        test_hidden_arb();
        test_park_start_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
